// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain driver.
// Holds the driver FSM state encoding and a ceil-divide used to size word counts.
// No ports; imported by ccff_bit_counter and ccff_chain_driver.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L_FETCH = 3'd1,
    L_SHIFT = 3'd2,
    R_SHIFT = 3'd3,
    R_PUSH  = 3'd4,
    DONE    = 3'd5
  } ccff_state_e;

  // Number of DATA-wide words needed to cover a chain of len bits.
  function automatic int ccff_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/ccff_bit_counter.sv
// Purpose: loadable down-counter of chain bits still to shift, plus the bit index within the current word.
// Latency: registered; load/clear/decrement take effect on the next prog_clk_i edge.
// Backpressure: none; only advances when the owner asserts dec_i (i.e. when the chain actually shifts).
// Ports: prog_clk_i/rst_i clock and async active-high reset; load_i reloads remaining to CHAIN_LEN and
//        clears the index; clr_idx_i starts a new word; dec_i counts one shifted bit;
//        remaining_o bits left in the operation; idx_o position of the current bit within its word.
module ccff_bit_counter
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
  parameter int IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic             prog_clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clr_idx_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] remaining_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    rem_d = rem_q;
    idx_d = idx_q;
    if (load_i) begin
      rem_d = CNT_W'(CHAIN_LEN);
      idx_d = '0;
    end else begin
      if (clr_idx_i) begin
        idx_d = '0;
      end
      if (dec_i) begin
        // Saturate at zero so remaining never wraps.
        if (rem_q != '0) begin
          rem_d = rem_q - CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      idx_q <= '0;
    end else begin
      rem_q <= rem_d;
      idx_q <= idx_d;
    end
  end

  assign remaining_o = rem_q;
  assign idx_o       = idx_q;

endmodule

// File: rtl/ccff_chain_driver.sv
// Purpose: serialises bitstream words onto a fabric config chain; optional non-destructive readback.
// Latency: per word 1 accept cycle + k shift cycles on load; k shift cycles + >=1 push cycle on readback.
// Backpressure: s_ready only in L_FETCH; chain holds (config_enable=0) while m_valid waits for m_ready.
// Ports: prog_clk/pReset clock and async active-high reset; start_load/start_rb start pulses;
//        s_valid/s_data/s_ready input word stream; m_valid/m_data/m_ready readback word stream;
//        ccff_head/ccff_tail chain ends; config_enable shift enable; config_readback, busy, done status.
// Build option: define CCFF_CHAIN_DRIVER_READBACK_EN to include the readback path.
module ccff_chain_driver
  import ccff_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_load,
  input  logic              start_rb,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              config_readback,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ccff_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cnt_load, cnt_clr, cnt_dec;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  bit_idx;
  logic              word_last;
  logic              rem_one;
  logic              rem_zero;

  ccff_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_cnt (
    .prog_clk_i  (prog_clk),
    .rst_i       (pReset),
    .load_i      (cnt_load),
    .clr_idx_i   (cnt_clr),
    .dec_i       (cnt_dec),
    .remaining_o (remaining),
    .idx_o       (bit_idx)
  );

  assign rem_one  = (remaining == CNT_W'(1));
  assign rem_zero = (remaining == '0);
  // The bit being shifted this cycle closes the word when the word is full or the chain runs out.
  assign word_last = (bit_idx == IDX_W'(DATA_W - 1)) || rem_one;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_clr  = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d  = L_FETCH;
          cnt_load = 1'b1;
        end
`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
        else if (start_rb) begin
          state_d  = R_SHIFT;
          cnt_load = 1'b1;
        end
`endif
      end
      L_FETCH: begin
        if (s_valid) begin
          state_d = L_SHIFT;
          cnt_clr = 1'b1;
        end
      end
      L_SHIFT: begin
        cnt_dec = 1'b1;
        if (word_last) begin
          state_d = rem_one ? DONE : L_FETCH;
        end
      end
`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
      R_SHIFT: begin
        cnt_dec = 1'b1;
        if (word_last) begin
          state_d = R_PUSH;
        end
      end
      R_PUSH: begin
        if (m_ready) begin
          if (rem_zero) begin
            state_d = DONE;
          end else begin
            state_d = R_SHIFT;
            cnt_clr = 1'b1;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    if (state_q == L_FETCH && s_valid) begin
      shreg_d = s_data;
    end else if (state_q == L_SHIFT) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Status strobes come straight from the state register so the chain enable cannot glitch.
  assign s_ready = (state_q == L_FETCH);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
  logic [DATA_W-1:0] cap_q;

  // Capture is cleared at the start of every readback word so unused upper bits read as 0.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cap_q <= '0;
    end else if (cnt_load || (state_q == R_PUSH && cnt_clr)) begin
      cap_q <= '0;
    end else if (state_q == R_SHIFT) begin
      cap_q[bit_idx] <= ccff_tail;
    end
  end

  assign config_enable   = (state_q == L_SHIFT) || (state_q == R_SHIFT);
  assign config_readback = (state_q == R_SHIFT) || (state_q == R_PUSH);
  assign m_valid         = (state_q == R_PUSH);
  assign m_data          = cap_q;

  // Readback recirculates the tail straight back into the head so the chain is restored.
  always_comb begin
    ccff_head = 1'b0;
    if (state_q == L_SHIFT) begin
      ccff_head = shreg_q[0];
    end else if (state_q == R_SHIFT) begin
      ccff_head = ccff_tail;
    end
  end
`else
  logic unused_rb_inputs;
  assign unused_rb_inputs = ^{start_rb, m_ready, ccff_tail, rem_zero};

  assign config_enable   = (state_q == L_SHIFT);
  assign config_readback = 1'b0;
  assign m_valid         = 1'b0;
  assign m_data          = '0;
  assign ccff_head       = (state_q == L_SHIFT) ? shreg_q[0] : 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_driver.sv
module tb_ccff_chain_driver;

  localparam int DW = 8;
  localparam int CL = 44;

  logic          prog_clk   = 1'b0;
  logic          pReset     = 1'b1;
  logic          start_load = 1'b0;
  logic          start_rb   = 1'b0;
  logic          s_valid    = 1'b0;
  logic [DW-1:0] s_data     = '0;
  logic          m_ready    = 1'b0;
  logic          s_ready, m_valid, ccff_head, ccff_tail;
  logic          config_enable, config_readback, busy, done;
  logic [DW-1:0] m_data;

  ccff_chain_driver #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .start_load      (start_load),
    .start_rb        (start_rb),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_ready         (m_ready),
    .ccff_head       (ccff_head),
    .ccff_tail       (ccff_tail),
    .config_enable   (config_enable),
    .config_readback (config_readback),
    .busy            (busy),
    .done            (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters at the top, tail is bit 0.
  logic [CL-1:0] chain = '0;
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) if (config_enable) chain <= {ccff_head, chain[CL-1:1]};

  int cyc = 0, en_cnt = 0, rb_cnt = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (config_enable)     en_cnt   <= en_cnt + 1;
    if (config_readback)   rb_cnt   <= rb_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (s_valid && s_ready) acc_cyc <= cyc;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [DW-1:0] w);
    int t;
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    check("feed_ready", s_ready, 1);
    @(negedge prog_clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 500) begin
      @(negedge prog_clk);
      t++;
    end
    check("done_seen", done, 1);
    @(negedge prog_clk);
  endtask

  // Full load of 6 words; optionally also pulses start_rb with start_load, or start_rb mid-load.
  task automatic run_load(input logic [DW-1:0] w [6], input logic [CL-1:0] chain_exp,
                          input bit rb_with_start, input bit rb_mid);
    int e0, d0, r0, a0;
    e0 = en_cnt; d0 = done_cnt; r0 = rb_cnt;
    @(negedge prog_clk);
    start_load = 1'b1;
    start_rb   = rb_with_start;
    @(negedge prog_clk);
    start_load = 1'b0;
    start_rb   = 1'b0;
    feed(w[0]);
    a0 = acc_cyc;
    if (rb_mid) begin
      start_rb = 1'b1;
      @(negedge prog_clk);
      start_rb = 1'b0;
    end
    for (int i = 1; i < 6; i++) feed(w[i]);
    wait_done();
    check("load_en_cycles", en_cnt - e0, CL);
    check("load_done_pulses", done_cnt - d0, 1);
    check("load_latency", done_cyc - a0, 50);
    check("load_no_readback", rb_cnt - r0, 0);
    check("load_chain", chain, chain_exp);
  endtask

`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
  task automatic run_rb(input logic [DW-1:0] exp [6], input int stall_idx, input logic [CL-1:0] chain_exp);
    int t, bad, r0, d0;
    logic [DW-1:0] held;
    r0 = rb_cnt; d0 = done_cnt;
    @(negedge prog_clk);
    start_rb = 1'b1;
    @(negedge prog_clk);
    start_rb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t = 0;
      while (!m_valid && t < 200) begin
        @(negedge prog_clk);
        t++;
      end
      check("rb_valid", m_valid, 1);
      if (i == stall_idx) begin
        held = m_data;
        bad  = 0;
        repeat (10) begin
          @(negedge prog_clk);
          if (config_enable !== 1'b0 || m_valid !== 1'b1 || m_data !== held) bad++;
        end
        check("rb_stall_hold", bad, 0);
      end
      check("rb_word", m_data, exp[i]);
      m_ready = 1'b1;
      @(negedge prog_clk);
      m_ready = 1'b0;
    end
    wait_done();
    check("rb_done_pulses", done_cnt - d0, 1);
    check("rb_chain_restored", chain, chain_exp);
    check("rb_readback_high", (rb_cnt - r0) >= CL, 1);
  endtask
`endif

  initial begin
    int e0, t;
    // Reset state
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_head", ccff_head, 0);
    check("rst_cfg_en", config_enable, 0);
    check("rst_cfg_rb", config_readback, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge prog_clk);
    @(negedge prog_clk);
    pReset = 1'b0;

    // Load distinct words; last word is partial (4 of 8 bits kept)
    run_load('{8'h01, 8'h02, 8'h04, 8'h08, 8'h80, 8'hFF}, 44'hF8008040201, 1'b0, 1'b0);

`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
    run_rb('{8'h01, 8'h02, 8'h04, 8'h08, 8'h80, 8'h0F}, -1, 44'hF8008040201);
`else
    @(negedge prog_clk);
    start_rb = 1'b1;
    @(negedge prog_clk);
    start_rb = 1'b0;
    t = 0;
    repeat (5) begin
      if (busy !== 1'b0 || config_readback !== 1'b0 || m_valid !== 1'b0) t++;
      @(negedge prog_clk);
    end
    check("rb_ignored_when_disabled", t, 0);
`endif

    // Reset in the middle of a load, at bit 13
    e0 = en_cnt;
    @(negedge prog_clk);
    start_load = 1'b1;
    @(negedge prog_clk);
    start_load = 1'b0;
    feed(8'hFF);
    feed(8'hFF);
    t = 0;
    while ((en_cnt - e0) < 13 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("mid_bit_index", en_cnt - e0, 13);
    check("mid_cfg_en_before", config_enable, 1);
    pReset = 1'b1;
    #1;
    check("mid_rst_cfg_en", config_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_head", ccff_head, 0);
    check("mid_rst_cfg_rb", config_readback, 0);
    @(negedge prog_clk);
    pReset = 1'b0;

    // Complete load after reset, with a start_rb pulse while busy
    run_load('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 44'hFFFFFFFFFFF, 1'b0, 1'b1);

`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
    run_rb('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 2, 44'hFFFFFFFFFFF);
`endif

    // Simultaneous start pulses: load wins
    run_load('{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h06}, 44'h681F00F3CA5, 1'b1, 1'b0);

`ifdef CCFF_CHAIN_DRIVER_READBACK_EN
    run_rb('{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h06}, 4, 44'h681F00F3CA5);
`endif

    check("end_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
